fp_mult_arbiter: RTL
====================

# fp_mult_arbiter

Round-robin scheduler that shares one pipelined 32-bit floating-point multiplier (`fp_mult_32b` datapath) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one request per cycle, tags the issued operation with its requester ID through the fixed-latency multiplier pipeline, and returns the product on a shared result bus with a one-hot per-requester valid. It sits between the vector/accumulator clients and the single multiplier instance.

## Interface
Parameters:
- N, 32, floating-point word width
- ES, 8, exponent width, passed through to the multiplier
- NREQ, 4, number of requesters (2..16)
- MUL_LAT, 0, multiplier latency in cycles from its operand registers to a valid `result` (0 = combinational)

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant. Combinational, at most one bit high.
- req_a  in  NREQ*N  packed operand A. Requester i occupies bits [i*N +: N].
- req_b  in  NREQ*N  packed operand B, same packing as req_a
- rsp_valid  out  NREQ  one-hot result valid. Pulses for one cycle per completed operation.
- rsp_data  out  N  product for the requester flagged in rsp_valid
- busy  out  1  high while any accepted operation has not yet been returned

## Operation
- A handshake occurs for requester i in cycle t when req_valid[i] and req_ready[i] are both high.
- Arbitration is round-robin:
  - Pointer `prio` (log2 NREQ bits) names the highest-priority requester.
  - The grant goes to the first i with req_valid[i] high, searching prio, prio+1, … modulo NREQ.
  - req_ready is zero when no request is valid.
- Pointer update:
  - After a grant to i, prio becomes (i+1) mod NREQ, wrapping from NREQ-1 to 0.
  - With no grant, prio holds.
- Issue stage:
  - On the handshake edge, the selected req_a/req_b are captured into operand registers feeding the multiplier.
  - The tag {vld=1, id=i} is captured at the same edge.
  - With no handshake, vld=0 is captured and the operand registers hold their value. The multiplier input does not toggle.
- Tag pipeline:
  - MUL_LAT stages of {vld, id} shift in lockstep with the multiplier.
  - Their output is aligned with the multiplier `result`.
- Response stage:
  - rsp_data is registered from the multiplier result.
  - rsp_valid is registered as a one-hot decode of the aligned tag, or all zero when vld=0.
- There is no response backpressure. Requesters must accept rsp_valid whenever it pulses, and the block never stalls.
- busy = OR of vld over the issue register, all tag stages and the response register.
- Arithmetic (rounding, specials, width) is entirely owned by the multiplier. The block passes operands and result through unmodified.

## Timing
- Throughput is one operation per cycle.
- Latency: a request accepted in cycle t returns with rsp_valid high in exactly cycle t+MUL_LAT+2, for one cycle.
- Results return in grant order. A requester may hold several operations in flight.
- req_ready depends only on req_valid and prio, never on req_a/req_b. Requesters may drop req_valid without a handshake.
- Simultaneous requests from all NREQ requesters are each granted once within NREQ cycles (no starvation).
- Reset values:
  - req_ready=0 while rst is high.
  - prio=0.
  - All vld=0, rsp_valid=0, busy=0.
  - rsp_data=0 and operand registers=0.
- Reset asserted mid-operation: all in-flight operations are discarded and their rsp_valid never pulses. The first request after rst falls is granted under prio=0.

## Structure
- Package `fp_mult_arb_pkg`:
  - ID_W = $clog2(NREQ) helper
  - typedef `mul_tag_t` {logic vld; logic [ID_W-1:0] id}
  - localparam default NREQ
- Sub-module `rr_arbiter`: combinational grant plus the registered `prio`, parameterised by NREQ. It is reused by other shared-resource schedulers.
- `fp_mult_32b` is instantiated once inside the block. The tag shift register and response register stay in the top module.

## Test plan
- **Single request:** requester 2 issues a=0x40000000 (2.0), b=0x40400000 (3.0) with MUL_LAT=0 → req_ready[2] in the same cycle; rsp_valid=4'b0100 and rsp_data=0x40C00000 exactly 2 cycles later.
- **All four valid continuously, 8 cycles** → grants in order 0,1,2,3,0,1,2,3. Each rsp_valid matches its grant order MUL_LAT+2 cycles later.
- **Wrap-around:** prio=3 with req_valid=4'b1001 → grant 3, then 0. prio afterwards is 1.
- **Back-to-back from one requester** (only requester 1 valid, 5 cycles, distinct operands) → 5 consecutive rsp_valid=4'b0010 pulses in order. busy deasserts the cycle after the last.
- **Reset mid-flight:** three operations issued, rst pulsed 1 cycle later with MUL_LAT=3 → no rsp_valid pulses follow; busy=0 and prio=0 immediately.
- **No requests:** req_valid=0 for 10 cycles → req_ready, rsp_valid and busy stay 0. The multiplier operand registers hold their value.

Source files
------------

// File: rtl/fp_mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arb_pkg
// Brief    : Shared types and helpers for the multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mult_arb_pkg;

    localparam int NREQ_DEF = 4;

    // Requester-ID width; never below one bit so a 1-wide field stays legal.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_w(NREQ_DEF);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mul_tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_mult_32b.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_32b
// Brief    : IEEE-style multiplier, round-to-nearest-even, subnormals flushed.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_32b #(
    parameter int N   = 32,
    parameter int ES  = 8,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_result
);

    localparam int M  = N - ES - 1;
    localparam int EW = ES + 2;
    localparam logic [EW-1:0] C_BIAS = EW'((1 << (ES - 1)) - 1);
    localparam logic [EW-1:0] C_EMAX = EW'((1 << ES) - 1);

    logic          w_sa, w_sb, w_sign;
    logic [ES-1:0] w_ea, w_eb;
    logic [M-1:0]  w_fa, w_fb, w_frac;
    logic [2*M+1:0] w_prod;
    logic          w_norm, w_g, w_s;
    logic [M:0]    w_frac_r;
    logic [EW-1:0] w_exp;
    logic          w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_zero, w_b_zero;
    logic [N-1:0]  w_res;

    assign {w_sa, w_ea, w_fa} = i_a;
    assign {w_sb, w_eb, w_fb} = i_b;
    assign w_prod = {{(M+1){1'b0}}, 1'b1, w_fa} * {{(M+1){1'b0}}, 1'b1, w_fb};

    always_comb begin
        w_a_zero = (w_ea == '0);
        w_b_zero = (w_eb == '0);
        w_a_inf  = (w_ea == '1) && (w_fa == '0);
        w_b_inf  = (w_eb == '1) && (w_fb == '0);
        w_a_nan  = (w_ea == '1) && (w_fa != '0);
        w_b_nan  = (w_eb == '1) && (w_fb != '0);
        w_sign   = w_sa ^ w_sb;
        w_norm   = w_prod[2*M+1];
        if (w_norm) begin
            w_frac = w_prod[2*M:M+1];
            w_g    = w_prod[M];
            w_s    = |w_prod[M-1:0];
        end else begin
            w_frac = w_prod[2*M-1:M];
            w_g    = w_prod[M-1];
            w_s    = |w_prod[M-2:0];
        end
        w_frac_r = {1'b0, w_frac} + {{M{1'b0}}, w_g & (w_s | w_frac[0])};
        // Rounding carry-out leaves the fraction all-zero, so only the exponent moves.
        w_exp = {2'b00, w_ea} + {2'b00, w_eb} - C_BIAS
              + {{(EW-1){1'b0}}, w_norm} + {{(EW-1){1'b0}}, w_frac_r[M]};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res = {1'b0, {ES{1'b1}}, 1'b1, {(M-1){1'b0}}};
        end else if (w_a_inf || w_b_inf) begin
            w_res = {w_sign, {ES{1'b1}}, {M{1'b0}}};
        end else if (w_a_zero || w_b_zero || w_exp[EW-1] || (w_exp == '0)) begin
            w_res = {w_sign, {(N-1){1'b0}}};
        end else if (w_exp >= C_EMAX) begin
            w_res = {w_sign, {ES{1'b1}}, {M{1'b0}}};
        end else begin
            w_res = {w_sign, w_exp[ES-1:0], w_frac_r[M-1:0]};
        end
    end

    generate
        if (LAT == 0) begin : g_comb
            assign o_result = w_res;
        end else begin : g_pipe
            logic [N-1:0] r_pipe [LAT];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < LAT; s++) r_pipe[s] <= '0;
                end else begin
                    r_pipe[0] <= w_res;
                    for (int s = 1; s < LAT; s++) r_pipe[s] <= r_pipe[s-1];
                end
            end
            assign o_result = r_pipe[LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant with a registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req,
    output logic [NREQ-1:0]         o_gnt,
    output logic [id_w(NREQ)-1:0]   o_gnt_id,
    output logic                    o_gnt_any
);

    localparam int IW = id_w(NREQ);

    logic [IW-1:0] r_prio;
    int            w_idx;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_id  = '0;
        o_gnt_any = 1'b0;
        w_idx     = 0;
        if (!rst) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                w_idx = (int'(r_prio) + k) % NREQ;
                if (i_req[w_idx]) begin
                    o_gnt_id  = IW'(w_idx);
                    o_gnt_any = 1'b1;
                end
            end
            if (o_gnt_any) begin
                o_gnt[o_gnt_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= '0;
        end else if (o_gnt_any) begin
            r_prio <= (o_gnt_id == IW'(NREQ - 1)) ? '0 : o_gnt_id + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arbiter
// Brief    : Round-robin sharing of one pipelined FP multiplier among NREQ clients.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int N       = 32,
    parameter int ES      = 8,
    parameter int NREQ    = NREQ_DEF,
    parameter int MUL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              busy
);

    localparam int IW = id_w(NREQ);

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] id;
    } tag_t;

    logic [IW-1:0]   w_gnt_id;
    logic            w_gnt_any;
    logic [N-1:0]    r_op_a, r_op_b, w_result, r_rsp_data;
    logic [NREQ-1:0] r_rsp_valid;
    tag_t            r_tag_issue, w_tag_aligned;
    logic            w_pipe_busy;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .o_gnt     (req_ready),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    // Operands only load on a handshake so the multiplier input stays quiet when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_tag_issue <= '0;
        end else begin
            r_tag_issue <= '{vld: w_gnt_any, id: w_gnt_id};
            if (w_gnt_any) begin
                r_op_a <= req_a[int'(w_gnt_id)*N +: N];
                r_op_b <= req_b[int'(w_gnt_id)*N +: N];
            end
        end
    end

    fp_mult_32b #(.N(N), .ES(ES), .LAT(MUL_LAT)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_result)
    );

    generate
        if (MUL_LAT == 0) begin : g_tag_comb
            assign w_tag_aligned = r_tag_issue;
            assign w_pipe_busy   = 1'b0;
        end else begin : g_tag_pipe
            tag_t r_tag [MUL_LAT];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < MUL_LAT; s++) r_tag[s] <= '0;
                end else begin
                    r_tag[0] <= r_tag_issue;
                    for (int s = 1; s < MUL_LAT; s++) r_tag[s] <= r_tag[s-1];
                end
            end
            always_comb begin
                w_pipe_busy = 1'b0;
                for (int s = 0; s < MUL_LAT; s++) w_pipe_busy = w_pipe_busy | r_tag[s].vld;
            end
            assign w_tag_aligned = r_tag[MUL_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_tag_aligned.vld ? (NREQ'(1) << w_tag_aligned.id) : '0;
            if (w_tag_aligned.vld) begin
                r_rsp_data <= w_result;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_tag_issue.vld | w_pipe_busy | (|r_rsp_valid);

endmodule
`default_nettype wire
